// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared types and constants for the two-port memory bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Combinational two-way round-robin picker; ties go to the port
//          that did not win last time.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    case (req)
      2'b01:   winner = PORT_CPU;
      2'b10:   winner = PORT_DBG;
      2'b11:   winner = ~last;
      default: winner = PORT_CPU;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Shares one memory between CPU (port 0) and debug loader (port 1),
//          one transaction at a time with round-robin arbitration.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] C_RD_LAT = CNT_W'(RD_LAT);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rr_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_valid;
  logic              w_winner;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (r_rr_last),
    .valid  (w_valid),
    .winner (w_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next_state = ACCESS;
      ACCESS:  w_next_state = r_we ? DONE : WAIT;
      WAIT:    if (r_cnt == CNT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Captured request stays frozen from IDLE until the next win, so later
  // requester changes cannot disturb the transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win     <= PORT_CPU;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rr_last <= PORT_DBG;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_win     <= w_winner;
            r_we      <= w_winner ? we1 : we0;
            r_addr    <= w_winner ? addr1 : addr0;
            r_wdata   <= w_winner ? wdata1 : wdata0;
            r_rr_last <= w_winner;
          end
        end
        ACCESS: begin
          if (!r_we) r_cnt <= C_RD_LAT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Handshake and strobes decode straight from state so reset drops them
  // without waiting for a clock edge.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    busy   = (r_state != IDLE);
    if (r_state == ACCESS) begin
      gnt0   = (r_win == PORT_CPU);
      gnt1   = (r_win == PORT_DBG);
      mem_rd = ~r_we;
      mem_wr = r_we;
    end
    if (r_state == DONE) begin
      ack0 = (r_win == PORT_CPU);
      ack1 = (r_win == PORT_DBG);
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module : tb_mem_bus_arbiter
// Brief  : Directed self-checking bench; RD_LAT=1 and RD_LAT=3 instances.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // RD_LAT=1 instance
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, mem_rdata;
  logic       gnt0, gnt1, ack0, ack1, busy, mem_rd, mem_wr;
  logic [7:0] rdata, mem_wdata;
  logic [4:0] mem_addr;

  // RD_LAT=3 instance
  logic       b_req0, b_req1, b_we0, b_we1;
  logic [4:0] b_addr0, b_addr1;
  logic [7:0] b_wdata0, b_wdata1, b_mem_rdata;
  logic       b_gnt0, b_gnt1, b_ack0, b_ack1, b_busy, b_mem_rd, b_mem_wr;
  logic [7:0] b_rdata, b_mem_wdata;
  logic [4:0] b_mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
    .busy(b_busy), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_rdata(b_mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; mem_rdata = 0;
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = 0; b_addr1 = 0;
    b_wdata0 = 0; b_wdata1 = 0; b_mem_rdata = 0;
    tick; tick;
    n_cmp++; if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy} !== 7'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0000000", {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy}); end
    n_cmp++; if ({rdata, mem_addr, mem_wdata} !== 21'h0) begin n_err++; $display("FAIL rst_data: got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata); end
    n_cmp++; if ({b_busy, b_gnt0, b_gnt1, b_rdata} !== 11'h0) begin n_err++; $display("FAIL rst_dut3: got busy=%b gnt=%b%b rdata=%h want 0", b_busy, b_gnt0, b_gnt1, b_rdata); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    req0 = 1; we0 = 0; addr0 = 5'h0A; mem_rdata = 8'h3C;
    tick;
    n_cmp++; if ({gnt0, gnt1, mem_rd, mem_wr, busy} !== 5'b10101) begin n_err++; $display("FAIL rd_access: got gnt0,gnt1,rd,wr,busy=%b want 10101", {gnt0, gnt1, mem_rd, mem_wr, busy}); end
    n_cmp++; if (mem_addr !== 5'h0A) begin n_err++; $display("FAIL rd_addr: got %h want 0a", mem_addr); end
    req0 = 0; addr0 = 5'h00;
    tick;
    n_cmp++; if ({mem_rd, mem_wr, gnt0, ack0, busy} !== 5'b00001) begin n_err++; $display("FAIL rd_wait: got rd,wr,gnt0,ack0,busy=%b want 00001", {mem_rd, mem_wr, gnt0, ack0, busy}); end
    n_cmp++; if (mem_addr !== 5'h0A) begin n_err++; $display("FAIL rd_addr_hold: got %h want 0a", mem_addr); end
    tick;
    n_cmp++; if ({ack0, ack1, busy} !== 3'b101) begin n_err++; $display("FAIL rd_ack: got ack0,ack1,busy=%b want 101", {ack0, ack1, busy}); end
    n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL rd_data: got %h want 3c", rdata); end
    tick;
    n_cmp++; if ({ack0, busy} !== 2'b00) begin n_err++; $display("FAIL rd_idle: got ack0,busy=%b want 00", {ack0, busy}); end
  endtask

  task automatic test_single_write;
    req1 = 1; we1 = 1; addr1 = 5'h1F; wdata1 = 8'hA5; mem_rdata = 8'h77;
    tick;
    n_cmp++; if ({gnt0, gnt1, mem_rd, mem_wr, busy} !== 5'b01011) begin n_err++; $display("FAIL wr_access: got gnt0,gnt1,rd,wr,busy=%b want 01011", {gnt0, gnt1, mem_rd, mem_wr, busy}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {5'h1F, 8'hA5}) begin n_err++; $display("FAIL wr_bus: got addr=%h wdata=%h want 1f a5", mem_addr, mem_wdata); end
    req1 = 0; we1 = 0; wdata1 = 8'h00;
    tick;
    n_cmp++; if ({ack0, ack1, gnt1, mem_wr} !== 4'b0100) begin n_err++; $display("FAIL wr_ack: got ack0,ack1,gnt1,wr=%b want 0100", {ack0, ack1, gnt1, mem_wr}); end
    n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL wr_rdata_kept: got %h want 3c", rdata); end
    tick;
    n_cmp++; if ({busy, mem_addr, mem_wdata} !== {1'b0, 5'h1F, 8'hA5}) begin n_err++; $display("FAIL wr_idle_hold: got busy=%b addr=%h wdata=%h want 0 1f a5", busy, mem_addr, mem_wdata); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_port;
    int ng;
    exp_port = 4'b1010;   // grant k expects port exp_port[k]
    ng = 0;
    rst = 1'b0; tick; rst = 1'b1;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 5'h01; addr1 = 5'h02;
    wdata0 = 8'h11; wdata1 = 8'h22;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick;
      n_cmp++; if ((gnt0 && gnt1) || (ack0 && ack1)) begin n_err++; $display("FAIL cont_excl: got gnt=%b%b ack=%b%b want one-hot", gnt0, gnt1, ack0, ack1); end
      if (gnt0 || gnt1) begin
        n_cmp++; if ({gnt1, mem_addr} !== {exp_port[ng], exp_port[ng] ? 5'h02 : 5'h01}) begin n_err++; $display("FAIL cont_order%0d: got port=%b addr=%h want port=%b", ng, gnt1, mem_addr, exp_port[ng]); end
        ng++;
        if (ng == 4) begin req0 = 0; req1 = 0; end
      end
    end
    n_cmp++; if (ng != 4) begin n_err++; $display("FAIL cont_timeout: got %0d grants want 4", ng); end
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    tick;
    n_cmp++; if ({ack0, ack1} !== 2'b01) begin n_err++; $display("FAIL cont_last_ack: got ack0,ack1=%b want 01", {ack0, ack1}); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_rd_lat3;
    b_req1 = 1; b_we1 = 0; b_addr1 = 5'h07; b_mem_rdata = 8'h55;
    tick;
    n_cmp++; if ({b_gnt0, b_gnt1, b_mem_rd, b_mem_wr, b_busy} !== 5'b01101) begin n_err++; $display("FAIL l3_access: got gnt0,gnt1,rd,wr,busy=%b want 01101", {b_gnt0, b_gnt1, b_mem_rd, b_mem_wr, b_busy}); end
    b_req1 = 0; b_addr1 = 5'h00;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if ({b_ack1, b_mem_rd, b_busy, b_rdata, b_mem_addr} !== {3'b001, 8'h00, 5'h07}) begin n_err++; $display("FAIL l3_wait%0d: got ack1,rd,busy=%b rdata=%h addr=%h want 001 00 07", k, {b_ack1, b_mem_rd, b_busy}, b_rdata, b_mem_addr); end
      if (k == 0) b_mem_rdata = 8'h99;
      if (k == 2) b_mem_rdata = 8'hC7;
    end
    tick;
    n_cmp++; if ({b_ack0, b_ack1, b_rdata} !== {2'b01, 8'hC7}) begin n_err++; $display("FAIL l3_ack: got ack0,ack1=%b rdata=%h want 01 c7", {b_ack0, b_ack1}, b_rdata); end
    b_mem_rdata = 8'h00;
    tick;
    n_cmp++; if ({b_ack1, b_busy, b_rdata} !== {2'b00, 8'hC7}) begin n_err++; $display("FAIL l3_idle: got ack1,busy=%b rdata=%h want 00 c7", {b_ack1, b_busy}, b_rdata); end
  endtask

  task automatic test_reset_mid;
    req0 = 1; we0 = 0; addr0 = 5'h03; mem_rdata = 8'h5A;
    tick;
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL rm_gnt: got %b want 1", gnt0); end
    tick;
    n_cmp++; if ({busy, mem_rd, ack0} !== 3'b100) begin n_err++; $display("FAIL rm_wait: got busy,rd,ack0=%b want 100", {busy, mem_rd, ack0}); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy} !== 7'b0) begin n_err++; $display("FAIL rm_async: got %b want 0000000", {gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy}); end
    n_cmp++; if (mem_addr !== 5'h00) begin n_err++; $display("FAIL rm_addr: got %h want 00", mem_addr); end
    req1 = 1; we1 = 0; addr1 = 5'h04;
    tick;
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_err++; $display("FAIL rm_noack: got ack0,ack1,busy=%b want 000", {ack0, ack1, busy}); end
    rst = 1'b1;
    tick;
    n_cmp++; if ({gnt0, gnt1, mem_addr} !== {2'b10, 5'h03}) begin n_err++; $display("FAIL rm_first: got gnt0,gnt1=%b addr=%h want 10 03", {gnt0, gnt1}, mem_addr); end
    req0 = 0; req1 = 0;
    tick; tick;
    n_cmp++; if ({ack0, rdata} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL rm_ack: got ack0=%b rdata=%h want 1 5a", ack0, rdata); end
    tick;
  endtask

  task automatic test_back_to_back;
    int last_ack;
    int idle_run;
    int ng;
    last_ack = -1; idle_run = 0; ng = 0;
    req0 = 1; we0 = 1; addr0 = 5'h10; wdata0 = 8'h42;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      tick;
      if (ack0) begin last_ack = c; idle_run = 0; end
      else if (!busy) idle_run++;
      if (gnt0) begin
        if (last_ack >= 0) begin
          n_cmp++; if (c - last_ack != 2) begin n_err++; $display("FAIL b2b_gap%0d: got %0d cycles want 2", ng, c - last_ack); end
          n_cmp++; if (idle_run != 1) begin n_err++; $display("FAIL b2b_idle%0d: got %0d idle cycles want 1", ng, idle_run); end
        end
        ng++;
        if (ng == 3) req0 = 0;
      end
    end
    n_cmp++; if (ng != 3) begin n_err++; $display("FAIL b2b_timeout: got %0d grants want 3", ng); end
    tick; tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_rd_lat3;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
